instr_fetch_stage: RTL and testbench

- IF stage of the pipelined MIPS CPU: owns instruction memory, its sequential load path, the PC and the IF/ID pipeline register.
- Feeds the decode stage with `if_id_instr` and `if_id_pc4`.
- Accepts stall and branch-redirect inputs back from decode.
- Program is streamed in one word per clock while `LoadInstructions` is high; fetch runs from PC 0 once loading ends.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/instr_mem.sv | 32 +++
 rtl/instr_fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_instr_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the CPU pipeline stages.
//   NOP_INSTR - encoding injected into the pipeline for bubbles/flushes
//   INSTR_W   - architectural instruction width
//   PC_RESET  - program counter value after Reset and during loading
//   fetch_sel_e - which action the IF stage takes on an edge, in priority order
package cpu_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_RESET  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_ADVANCE  = 2'd0,
    FETCH_HOLD     = 2'd1,
    FETCH_REDIRECT = 2'd2
  } fetch_sel_e;

endpackage

// File: rtl/instr_mem.sv
// instr_mem: instruction storage, DEPTH words of DATA_W bits.
//   clk     - rising-edge clock for writes
//   we_i    - write enable
//   waddr_i - word index to write
//   wdata_i - word to write
//   raddr_i - word index to read
//   rdata_o - combinational read data
// The array has no reset so a loaded program survives a CPU Reset.
module instr_mem #(
  parameter  int DEPTH  = 64,
  parameter  int DATA_W = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: IF stage of the pipelined MIPS CPU.
// Owns the instruction memory and its sequential loader, the PC and the
// IF/ID pipeline register.
//   clk, Reset           - clock, asynchronous active-high reset
//   LoadInstructions     - load mode: one Instruction word written per edge
//   Instruction          - word to load
//   stall                - hold PC and IF/ID (from ID hazard unit)
//   branch_taken         - redirect PC to branch_target, flush IF/ID
//   branch_target        - byte address of redirect (low 2 bits ignored)
//   if_id_instr/pc4/valid- IF/ID register contents towards decode
//   load_count           - words loaded since last Reset
//   load_full            - memory filled, further load words dropped
// Optional build macro IFETCH_PERF_EN adds fetch_count and bubble_count
// (saturating performance counters, cleared by Reset).
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter  int DEPTH  = 64,
  parameter  int DATA_W = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              LoadInstructions,
  input  logic [DATA_W-1:0] Instruction,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [31:0]       if_id_pc4,
  output logic              if_id_valid,
`ifdef IFETCH_PERF_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       bubble_count,
`endif
  output logic [ADDR_W:0]   load_count,
  output logic              load_full
);

  localparam logic [DATA_W-1:0] NOP_W     = DATA_W'(NOP_INSTR);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [31:0]       pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  // Length of the most recent program. Deliberately not cleared by Reset:
  // it describes memory contents, which also survive Reset, and is what
  // makes fetches past the end of the program return NOP.
  logic [ADDR_W:0]   prog_len_q, prog_len_d;

  logic              full;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_ok;
  logic [DATA_W-1:0] fetch_word;
  fetch_sel_e        fetch_sel;

  assign full   = (wr_ptr_q == DEPTH_CNT);
  assign mem_we = LoadInstructions && !full;

  instr_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (Instruction),
    .raddr_i (pc_q[ADDR_W+1:2]),
    .rdata_o (mem_rdata)
  );

  // A read is real only inside the memory window and below the program end.
  assign rd_ok      = (pc_q[31:ADDR_W+2] == '0) &&
                      ({1'b0, pc_q[ADDR_W+1:2]} < prog_len_q);
  assign fetch_word = rd_ok ? mem_rdata : NOP_W;

  always_comb begin
    fetch_sel = FETCH_ADVANCE;
    if (branch_taken) begin
      fetch_sel = FETCH_REDIRECT;
    end else if (stall) begin
      fetch_sel = FETCH_HOLD;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    if (LoadInstructions) begin
      pc_d    = PC_RESET;
      instr_d = NOP_W;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
      if (mem_we) begin
        wr_ptr_d   = wr_ptr_q + 1'b1;
        prog_len_d = wr_ptr_q + 1'b1;
      end
    end else begin
      unique case (fetch_sel)
        FETCH_REDIRECT: begin
          pc_d    = branch_target & ~32'h3;
          instr_d = NOP_W;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
        end
        FETCH_HOLD: ;
        FETCH_ADVANCE: begin
          instr_d = fetch_word;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pc_q     <= PC_RESET;
      instr_q  <= NOP_W;
      pc4_q    <= 32'h0;
      valid_q  <= 1'b0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    prog_len_q <= prog_len_d;
  end

  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign load_count  = wr_ptr_q;
  assign load_full   = full;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (!LoadInstructions) begin
      if (fetch_sel == FETCH_ADVANCE && fetch_cnt_q != 32'hFFFF_FFFF) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (fetch_sel != FETCH_ADVANCE && bubble_cnt_q != 32'hFFFF_FFFF) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed self-checking bench for instr_fetch_stage.
module tb_instr_fetch_stage;

  logic        clk;
  logic        Reset;
  logic        LoadInstructions;
  logic [31:0] Instruction;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [6:0]  load_count;
  logic        load_full;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int n_checks = 0;
  int n_err    = 0;

  instr_fetch_stage #(.DEPTH(64), .DATA_W(32)) dut (
    .clk              (clk),
    .Reset            (Reset),
    .LoadInstructions (LoadInstructions),
    .Instruction      (Instruction),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .if_id_instr      (if_id_instr),
    .if_id_pc4        (if_id_pc4),
    .if_id_valid      (if_id_valid),
`ifdef IFETCH_PERF_EN
    .fetch_count      (fetch_count),
    .bubble_count     (bubble_count),
`endif
    .load_count       (load_count),
    .load_full        (load_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    LoadInstructions = 1'b1;
    Instruction      = w;
    tick();
    $display("load %h -> load_count=%0d full=%0b", w, load_count, load_full);
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid);
    tick();
    $display("%s: instr=%h pc4=%h valid=%0b", tag, if_id_instr, if_id_pc4, if_id_valid);
    chk({tag, ".instr"}, if_id_instr, e_instr);
    chk({tag, ".pc4"},   if_id_pc4,   e_pc4);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(e_valid));
  endtask

  initial begin
    Reset = 1'b1; LoadInstructions = 1'b0; Instruction = '0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    tick(); tick();
    chk("rst.instr", if_id_instr, 32'h0);
    chk("rst.pc4", if_id_pc4, 32'h0);
    chk("rst.valid", 32'(if_id_valid), 32'h0);
    chk("rst.count", 32'(load_count), 32'h0);
    chk("rst.full", 32'(load_full), 32'h0);

    // 1: load three words, Reset pulse, program survives and runs
    #2 Reset = 1'b0;
    load_word(32'h200101A7);
    load_word(32'h2002005C);
    load_word(32'h2003000D);
    chk("t1.count", 32'(load_count), 32'd3);
    chk("t1.load_valid", 32'(if_id_valid), 32'h0);
    LoadInstructions = 1'b0;
    reset_pulse();
    chk("t1.count_rst", 32'(load_count), 32'd0);
    fetch_chk("t1.f0", 32'h200101A7, 32'd4, 1'b1);
    fetch_chk("t1.f1", 32'h2002005C, 32'd8, 1'b1);
    fetch_chk("t1.f2", 32'h2003000D, 32'd12, 1'b1);
    fetch_chk("t1.f3", 32'h00000000, 32'd16, 1'b1);

    // 3: stall at PC=8
    reset_pulse();
    fetch_chk("t3.f0", 32'h200101A7, 32'd4, 1'b1);
    fetch_chk("t3.f1", 32'h2002005C, 32'd8, 1'b1);
    stall = 1'b1;
    fetch_chk("t3.s0", 32'h2002005C, 32'd8, 1'b1);
    fetch_chk("t3.s1", 32'h2002005C, 32'd8, 1'b1);
    stall = 1'b0;
    fetch_chk("t3.rel", 32'h2003000D, 32'd12, 1'b1);

    // 4: branch with stall at PC=12 flushes, then fetches mem[1]
    branch_taken = 1'b1; branch_target = 32'h4; stall = 1'b1;
    fetch_chk("t4.flush", 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0; stall = 1'b0;
    fetch_chk("t4.tgt", 32'h2002005C, 32'd8, 1'b1);
    // unaligned target, low bits dropped
    branch_taken = 1'b1; branch_target = 32'h7;
    tick();
    branch_taken = 1'b0;
    fetch_chk("t4.align", 32'h2002005C, 32'd8, 1'b1);
    // beyond memory window: index bits alias a loaded word but must be NOP
    branch_taken = 1'b1; branch_target = 32'h107;
    tick();
    branch_taken = 1'b0;
    fetch_chk("t4.oob", 32'h0, 32'h108, 1'b1);
    // PC wraps modulo 2^32
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    fetch_chk("t4.wrap", 32'h0, 32'h0, 1'b1);
    // async reset mid-fetch clears IF/ID without a clock
    Reset = 1'b1;
    #1;
    chk("t4.arst.valid", 32'(if_id_valid), 32'h0);
    chk("t4.arst.pc4", if_id_pc4, 32'h0);
    Reset = 1'b0;

    // 5: async reset mid-load, reload overwrites mem[0]
    load_word(32'hAAAA0001);
    load_word(32'hAAAA0002);
    chk("t5.count2", 32'(load_count), 32'd2);
    Reset = 1'b1;
    #1;
    chk("t5.arst.count", 32'(load_count), 32'd0);
    chk("t5.arst.instr", if_id_instr, 32'h0);
    Reset = 1'b0;
    load_word(32'hBBBB0001);
    chk("t5.count1", 32'(load_count), 32'd1);
    LoadInstructions = 1'b0;
    fetch_chk("t5.f0", 32'hBBBB0001, 32'd4, 1'b1);
    fetch_chk("t5.stale", 32'h0, 32'd8, 1'b1);

    // 2: overflow load, values 1..66
    reset_pulse();
    for (int i = 1; i <= 66; i++) begin
      LoadInstructions = 1'b1;
      Instruction      = 32'(i);
      tick();
      if (i == 63) chk("t2.full63", 32'(load_full), 32'h0);
      if (i == 64) begin
        chk("t2.full64", 32'(load_full), 32'h1);
        chk("t2.count64", 32'(load_count), 32'd64);
      end
    end
    $display("load 1..66 -> load_count=%0d full=%0b", load_count, load_full);
    chk("t2.count66", 32'(load_count), 32'd64);
    chk("t2.full66", 32'(load_full), 32'h1);
    LoadInstructions = 1'b0;
    fetch_chk("t2.mem0", 32'd1, 32'd4, 1'b1);
    branch_taken = 1'b1; branch_target = 32'hFC;
    tick();
    branch_taken = 1'b0;
    fetch_chk("t2.mem63", 32'd64, 32'h100, 1'b1);
    fetch_chk("t2.end", 32'h0, 32'h104, 1'b1);

`ifdef IFETCH_PERF_EN
    // 6: 5 fetches, 2 stalls, 1 branch
    reset_pulse();
    chk("t6.fc0", fetch_count, 32'd0);
    chk("t6.bc0", bubble_count, 32'd0);
    tick(); tick(); tick();
    stall = 1'b1;
    tick(); tick();
    stall = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h0;
    tick();
    branch_taken = 1'b0;
    tick(); tick();
    $display("perf: fetch_count=%0d bubble_count=%0d", fetch_count, bubble_count);
    chk("t6.fc", fetch_count, 32'd5);
    chk("t6.bc", bubble_count, 32'd3);
    reset_pulse();
    chk("t6.fc_rst", fetch_count, 32'd0);
    chk("t6.bc_rst", bubble_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
